// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared ALU op codes, forward-select codes and control bundle
// for the ID/EX pipeline register slice.
`default_nettype none

package id_ex_stage_pkg;

  localparam int DATA_WIDTH_DEF       = 32;
  localparam int ALU_OPTION_WIDTH_DEF = 3;
  localparam int REG_ADDR_WIDTH_DEF   = 5;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SLT = 3'd5;
  localparam logic [2:0] ALU_SLL = 3'd6;
  localparam logic [2:0] ALU_SRL = 3'd7;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_NONE  = 2'b00;
  localparam fwd_sel_t FWD_MEMWB = 2'b01;
  localparam fwd_sel_t FWD_EXMEM = 2'b10;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
  } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/id_ex_stage_forward_unit.sv
// forward_unit: picks the forwarding source for one EX-stage source operand.
// EX/MEM outranks MEM/WB; register x0 is never forwarded.
`default_nettype none

module forward_unit
  import id_ex_stage_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs_addr_i,
  input  logic                      ex_mem_reg_write_i,
  input  logic [REG_ADDR_WIDTH-1:0] ex_mem_rd_i,
  input  logic                      mem_wb_reg_write_i,
  input  logic [REG_ADDR_WIDTH-1:0] mem_wb_rd_i,
  output fwd_sel_t                  fwd_sel_o
);

  logic hit_exmem;
  logic hit_memwb;

  assign hit_exmem = ex_mem_reg_write_i && (ex_mem_rd_i != '0) && (ex_mem_rd_i == rs_addr_i);
  assign hit_memwb = mem_wb_reg_write_i && (mem_wb_rd_i != '0) && (mem_wb_rd_i == rs_addr_i);

  always_comb begin
    fwd_sel_o = FWD_NONE;
    if (hit_exmem) begin
      fwd_sel_o = FWD_EXMEM;
    end else if (hit_memwb) begin
      fwd_sel_o = FWD_MEMWB;
    end
  end

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with EX operand forwarding and load-use
// stall detection. Optional ID_EX_PERF_CNT_EN adds stall/forward counters.
`default_nettype none

module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_WIDTH       = DATA_WIDTH_DEF,
  parameter int ALU_OPTION_WIDTH = ALU_OPTION_WIDTH_DEF,
  parameter int REG_ADDR_WIDTH   = REG_ADDR_WIDTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        id_valid,
  input  logic [ALU_OPTION_WIDTH-1:0] id_alu_option,
  input  logic [REG_ADDR_WIDTH-1:0]   id_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0]   id_rs2_addr,
  input  logic [DATA_WIDTH-1:0]       id_rs1_data,
  input  logic [DATA_WIDTH-1:0]       id_rs2_data,
  input  logic                        id_uses_rs2,
  input  logic [DATA_WIDTH-1:0]       id_imm,
  input  logic                        id_alu_src_imm,
  input  logic [REG_ADDR_WIDTH-1:0]   id_rd_addr,
  input  logic                        id_reg_write,
  input  logic                        id_mem_read,
  input  logic                        id_mem_write,
  input  logic                        flush,
  input  logic                        ex_mem_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0]   ex_mem_rd,
  input  logic [DATA_WIDTH-1:0]       ex_mem_result,
  input  logic                        mem_wb_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0]   mem_wb_rd,
  input  logic [DATA_WIDTH-1:0]       mem_wb_data,
  output logic                        stall,
  output logic                        ex_valid,
  output logic [ALU_OPTION_WIDTH-1:0] ALU_option,
  output logic [DATA_WIDTH-1:0]       A,
  output logic [DATA_WIDTH-1:0]       B,
  output logic [DATA_WIDTH-1:0]       ex_store_data,
  output logic [REG_ADDR_WIDTH-1:0]   ex_rd,
  output logic                        ex_reg_write,
  output logic                        ex_mem_read,
  output logic                        ex_mem_write
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]                 stall_count,
  output logic [31:0]                 fwd_count
`endif
);

  logic                        valid_q, valid_d;
  logic [ALU_OPTION_WIDTH-1:0] alu_option_q, alu_option_d;
  logic [REG_ADDR_WIDTH-1:0]   rs1_addr_q, rs1_addr_d;
  logic [REG_ADDR_WIDTH-1:0]   rs2_addr_q, rs2_addr_d;
  logic [DATA_WIDTH-1:0]       rs1_data_q, rs1_data_d;
  logic [DATA_WIDTH-1:0]       rs2_data_q, rs2_data_d;
  logic [DATA_WIDTH-1:0]       imm_q, imm_d;
  logic                        alu_src_imm_q, alu_src_imm_d;
  logic [REG_ADDR_WIDTH-1:0]   rd_q, rd_d;
  ctrl_t                       ctrl_q, ctrl_d;

  fwd_sel_t                    fwd_sel_rs1;
  fwd_sel_t                    fwd_sel_rs2;
  logic [DATA_WIDTH-1:0]       rs1_fwd;
  logic [DATA_WIDTH-1:0]       rs2_fwd;
  logic                        rs_match;
  logic                        bubble;

  // Load-use: the value EX is loading is not available yet, so hold ID a cycle.
  assign rs_match = (id_rs1_addr == rd_q) || (id_uses_rs2 && (id_rs2_addr == rd_q));
  assign stall    = valid_q && ctrl_q.mem_read && (rd_q != '0) && id_valid && rs_match && !flush;
  assign bubble   = flush || stall;

  always_comb begin
    valid_d       = id_valid;
    alu_option_d  = id_alu_option;
    rs1_addr_d    = id_rs1_addr;
    rs2_addr_d    = id_rs2_addr;
    rs1_data_d    = id_rs1_data;
    rs2_data_d    = id_rs2_data;
    imm_d         = id_imm;
    alu_src_imm_d = id_alu_src_imm;
    rd_d          = id_rd_addr;
    ctrl_d        = '{reg_write: id_reg_write && id_valid,
                      mem_read:  id_mem_read  && id_valid,
                      mem_write: id_mem_write && id_valid};
    if (bubble) begin
      valid_d       = 1'b0;
      alu_option_d  = '0;
      rs1_addr_d    = '0;
      rs2_addr_d    = '0;
      rs1_data_d    = '0;
      rs2_data_d    = '0;
      imm_d         = '0;
      alu_src_imm_d = 1'b0;
      rd_d          = '0;
      ctrl_d        = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q       <= 1'b0;
      alu_option_q  <= '0;
      rs1_addr_q    <= '0;
      rs2_addr_q    <= '0;
      rs1_data_q    <= '0;
      rs2_data_q    <= '0;
      imm_q         <= '0;
      alu_src_imm_q <= 1'b0;
      rd_q          <= '0;
      ctrl_q        <= '0;
    end else begin
      valid_q       <= valid_d;
      alu_option_q  <= alu_option_d;
      rs1_addr_q    <= rs1_addr_d;
      rs2_addr_q    <= rs2_addr_d;
      rs1_data_q    <= rs1_data_d;
      rs2_data_q    <= rs2_data_d;
      imm_q         <= imm_d;
      alu_src_imm_q <= alu_src_imm_d;
      rd_q          <= rd_d;
      ctrl_q        <= ctrl_d;
    end
  end

  forward_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_rs1 (
    .rs_addr_i          (rs1_addr_q),
    .ex_mem_reg_write_i (ex_mem_reg_write),
    .ex_mem_rd_i        (ex_mem_rd),
    .mem_wb_reg_write_i (mem_wb_reg_write),
    .mem_wb_rd_i        (mem_wb_rd),
    .fwd_sel_o          (fwd_sel_rs1)
  );

  forward_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_rs2 (
    .rs_addr_i          (rs2_addr_q),
    .ex_mem_reg_write_i (ex_mem_reg_write),
    .ex_mem_rd_i        (ex_mem_rd),
    .mem_wb_reg_write_i (mem_wb_reg_write),
    .mem_wb_rd_i        (mem_wb_rd),
    .fwd_sel_o          (fwd_sel_rs2)
  );

  always_comb begin
    case (fwd_sel_rs1)
      FWD_EXMEM: rs1_fwd = ex_mem_result;
      FWD_MEMWB: rs1_fwd = mem_wb_data;
      default:   rs1_fwd = rs1_data_q;
    endcase
    case (fwd_sel_rs2)
      FWD_EXMEM: rs2_fwd = ex_mem_result;
      FWD_MEMWB: rs2_fwd = mem_wb_data;
      default:   rs2_fwd = rs2_data_q;
    endcase
  end

  assign ex_valid      = valid_q;
  assign ALU_option    = alu_option_q;
  assign A             = rs1_fwd;
  assign B             = alu_src_imm_q ? imm_q : rs2_fwd;
  assign ex_store_data = rs2_fwd;
  assign ex_rd         = rd_q;
  assign ex_reg_write  = ctrl_q.reg_write && valid_q;
  assign ex_mem_read   = ctrl_q.mem_read  && valid_q;
  assign ex_mem_write  = ctrl_q.mem_write && valid_q;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] stall_count_q, stall_count_d;
  logic [31:0] fwd_count_q, fwd_count_d;
  logic        fwd_any;

  assign fwd_any = valid_q && ((fwd_sel_rs1 != FWD_NONE) || (fwd_sel_rs2 != FWD_NONE));

  always_comb begin
    stall_count_d = stall_count_q + {31'd0, stall};
    fwd_count_d   = fwd_count_q + {31'd0, fwd_any};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count_q <= '0;
      fwd_count_q   <= '0;
    end else begin
      stall_count_q <= stall_count_d;
      fwd_count_q   <= fwd_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign fwd_count   = fwd_count_q;
`endif

endmodule

`default_nettype wire
